// File: rtl/ps2_disp_ctrl_pkg.sv
// Shared types, default prefix bytes and the keypress-count incrementer for the
// PS/2 keyboard to 7-segment display sequencer.
package ps2_disp_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAKE  = 2'd1,
    ST_BREAK = 2'd2
  } state_e;

  localparam logic [7:0] BREAK_CODE_DEF = 8'hF0;
  localparam logic [7:0] EXT_CODE_DEF   = 8'hE0;
  localparam bit         CNT_BCD_DEF    = 1'b1;

  // BCD mode wraps each nibble at 9 so the count reads 00..99 on two hex digits.
  function automatic logic [7:0] nextCount(input logic [7:0] cnt, input logic bcd);
    logic [7:0] res;
    res = cnt + 8'd1;
    if (bcd) begin
      if (cnt[3:0] >= 4'd9) begin
        res[3:0] = 4'd0;
        res[7:4] = (cnt[7:4] >= 4'd9) ? 4'd0 : (cnt[7:4] + 4'd1);
      end else begin
        res = {cnt[7:4], cnt[3:0] + 4'd1};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/ps2_disp_ctrl_if.sv
// Bundle of the receive-FIFO handshake and the three 7-seg driver inputs.
// master = the sequencer, slave = the FIFO/display environment.
interface ps2_disp_ctrl_if;

  logic       ready;
  logic [7:0] data;
  logic       overflow;
  logic       nextdata_n;
  logic       disp_en;
  logic [7:0] code_byte;
  logic [7:0] ascii_byte;
  logic [7:0] count_byte;
  logic       ovf_flag;

  modport master (
    input  ready,
    input  data,
    input  overflow,
    output nextdata_n,
    output disp_en,
    output code_byte,
    output ascii_byte,
    output count_byte,
    output ovf_flag
  );

  modport slave (
    output ready,
    output data,
    output overflow,
    input  nextdata_n,
    input  disp_en,
    input  code_byte,
    input  ascii_byte,
    input  count_byte,
    input  ovf_flag
  );

endinterface

// File: rtl/ps2_disp_ctrl_scancode_ascii.sv
// Combinational set-2 scan code to lowercase ASCII ROM; unmapped codes give 8'h00.
module scancode_ascii (
  input  logic [7:0] code_i,
  output logic [7:0] ascii_o
);

  always_comb begin
    ascii_o = 8'h00;
    case (code_i)
      8'h1C: ascii_o = 8'h61;
      8'h32: ascii_o = 8'h62;
      8'h21: ascii_o = 8'h63;
      8'h23: ascii_o = 8'h64;
      8'h24: ascii_o = 8'h65;
      8'h2B: ascii_o = 8'h66;
      8'h34: ascii_o = 8'h67;
      8'h33: ascii_o = 8'h68;
      8'h43: ascii_o = 8'h69;
      8'h3B: ascii_o = 8'h6A;
      8'h42: ascii_o = 8'h6B;
      8'h4B: ascii_o = 8'h6C;
      8'h3A: ascii_o = 8'h6D;
      8'h31: ascii_o = 8'h6E;
      8'h44: ascii_o = 8'h6F;
      8'h4D: ascii_o = 8'h70;
      8'h15: ascii_o = 8'h71;
      8'h2D: ascii_o = 8'h72;
      8'h1B: ascii_o = 8'h73;
      8'h2C: ascii_o = 8'h74;
      8'h3C: ascii_o = 8'h75;
      8'h2A: ascii_o = 8'h76;
      8'h1D: ascii_o = 8'h77;
      8'h22: ascii_o = 8'h78;
      8'h35: ascii_o = 8'h79;
      8'h1A: ascii_o = 8'h7A;
      8'h45: ascii_o = 8'h30;
      8'h16: ascii_o = 8'h31;
      8'h1E: ascii_o = 8'h32;
      8'h26: ascii_o = 8'h33;
      8'h25: ascii_o = 8'h34;
      8'h2E: ascii_o = 8'h35;
      8'h36: ascii_o = 8'h36;
      8'h3D: ascii_o = 8'h37;
      8'h3E: ascii_o = 8'h38;
      8'h46: ascii_o = 8'h39;
      // Whitespace and control keys map to their ASCII control characters.
      8'h29: ascii_o = 8'h20;
      8'h5A: ascii_o = 8'h0D;
      8'h66: ascii_o = 8'h08;
      8'h0D: ascii_o = 8'h09;
      8'h76: ascii_o = 8'h1B;
      8'h4E: ascii_o = 8'h2D;
      8'h55: ascii_o = 8'h3D;
      8'h41: ascii_o = 8'h2C;
      8'h49: ascii_o = 8'h2E;
      8'h4A: ascii_o = 8'h2F;
      8'h4C: ascii_o = 8'h3B;
      8'h52: ascii_o = 8'h27;
      8'h54: ascii_o = 8'h5B;
      8'h5B: ascii_o = 8'h5D;
      8'h5D: ascii_o = 8'h5C;
      8'h0E: ascii_o = 8'h60;
      default: ascii_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/ps2_disp_ctrl.sv
// Pops PS/2 scan-code bytes from the receive FIFO, tracks make/break/extended
// prefixes and drives the code, ASCII and keypress-count 7-seg displays.
module ps2_disp_ctrl
  import ps2_disp_ctrl_pkg::*;
#(
  parameter logic [7:0] BREAK_CODE = BREAK_CODE_DEF,
  parameter logic [7:0] EXT_CODE   = EXT_CODE_DEF,
  parameter bit         CNT_BCD    = CNT_BCD_DEF
) (
  input  logic            clk,
  input  logic            clrn,
  ps2_disp_ctrl_if.master bus
);

  state_e     state_q, state_d;
  logic [7:0] heldCode_q, heldCode_d;
  logic       heldValid_q, heldValid_d;
  logic [7:0] count_q, count_d;
  logic       pop_q, pop_d;
  logic       ovf_q, ovf_d;

  logic       dispEn_q;
  logic [7:0] codeByte_q;
  logic [7:0] asciiByte_q;
  logic [7:0] countByte_q;
  logic [7:0] asciiNext;

  scancode_ascii uRom (
    .code_i  (heldCode_q),
    .ascii_o (asciiNext)
  );

  // A pop is never issued in the cycle right after one, so the FIFO has a full
  // cycle to advance its head before ready is looked at again.
  always_comb begin
    state_d     = state_q;
    heldCode_d  = heldCode_q;
    heldValid_d = heldValid_q;
    count_d     = count_q;
    ovf_d       = ovf_q | bus.overflow;
    pop_d       = bus.ready & ~pop_q;

    if (pop_d && (bus.data != EXT_CODE)) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.data == BREAK_CODE) begin
            state_d     = ST_BREAK;
            heldValid_d = 1'b0;
          end else begin
            state_d     = ST_MAKE;
            heldCode_d  = bus.data;
            heldValid_d = 1'b1;
            count_d     = nextCount(count_q, CNT_BCD);
          end
        end
        ST_MAKE: begin
          if (bus.data == BREAK_CODE) begin
            state_d = ST_BREAK;
          end else if (bus.data != heldCode_q) begin
            heldCode_d = bus.data;
            count_d    = nextCount(count_q, CNT_BCD);
          end
        end
        ST_BREAK: begin
          // Releasing some other key leaves the held key on the display.
          if (bus.data == BREAK_CODE) begin
            state_d = ST_BREAK;
          end else if (heldValid_q && (bus.data == heldCode_q)) begin
            state_d     = ST_IDLE;
            heldValid_d = 1'b0;
          end else begin
            state_d = heldValid_q ? ST_MAKE : ST_IDLE;
          end
        end
        default: begin
          state_d     = ST_IDLE;
          heldValid_d = 1'b0;
        end
      endcase
    end
  end

  // Byte processing lands on the pop edge; the display registers follow one
  // clock later so every driver input changes together.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q     <= ST_IDLE;
      heldCode_q  <= 8'h00;
      heldValid_q <= 1'b0;
      count_q     <= 8'h00;
      pop_q       <= 1'b0;
      ovf_q       <= 1'b0;
      dispEn_q    <= 1'b0;
      codeByte_q  <= 8'h00;
      asciiByte_q <= 8'h00;
      countByte_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      heldCode_q  <= heldCode_d;
      heldValid_q <= heldValid_d;
      count_q     <= count_d;
      pop_q       <= pop_d;
      ovf_q       <= ovf_d;
      dispEn_q    <= heldValid_q;
      codeByte_q  <= heldCode_q;
      asciiByte_q <= asciiNext;
      countByte_q <= count_q;
    end
  end

  assign bus.nextdata_n = ~pop_q;
  assign bus.disp_en    = dispEn_q;
  assign bus.code_byte  = codeByte_q;
  assign bus.ascii_byte = asciiByte_q;
  assign bus.count_byte = countByte_q;
  assign bus.ovf_flag   = ovf_q;

endmodule
